ctrl_xfer_unit: RTL and testbench
=================================

// Module: ctrl_xfer_unit
// PURPOSE
//   Parametrised control-transfer unit: owns the PC register, resolves next PC for
//   JAL/JALR/branches, produces the rd link write (PC+4), and adds a return-address
//   stack (RAS) that predicts JALR returns, with miss/overflow statistics. Sits between
//   decode/ALU compare and instr_fetch in cpu_uart_top; replaces the bare prog_ctr.
// PARAMETERS
//   XLEN        32   datapath / PC width
//   RAS_DEPTH   8    RAS entries (power of 2, >=2)
//   PC_RESET    0    PC value after reset
//   ALIGN_CHECK 0    1: raise misalign_exc for target[1]!=0 and hold PC; 0: no check
//   CNT_W       16   width of saturating statistics counters
// PORTS
//   clk           in   1         system clock
//   rst           in   1         synchronous, active-high reset
//   stall         in   1         freeze PC, RAS and counters this cycle
//   instr_valid   in   1         decoded instruction present
//   is_jal        in   1         JAL
//   is_jalr       in   1         JALR
//   is_branch     in   1         conditional branch
//   branch_taken  in   1         ALU compare result
//   rd            in   5         destination register
//   rs1           in   5         source register 1 index
//   rs1_data      in   XLEN      rs1 value
//   imm           in   XLEN      sign-extended immediate
//   pc            out  XLEN      current PC
//   next_pc       out  XLEN      combinational next PC
//   link_we       out  1         write PC+4 to rd
//   link_rd       out  5         = rd
//   link_data     out  XLEN      = pc+4
//   ras_pred_vld  out  1         current JALR is a RAS pop with non-empty stack
//   ras_pred_ok   out  1         RAS top == computed JALR target
//   ras_count     out  $clog2(RAS_DEPTH)+1   valid entries
//   ras_ovf       out  1         sticky: push at full
//   ras_unf       out  1         sticky: pop at empty
//   misalign_exc  out  1         combinational, only if ALIGN_CHECK
//   jalr_cnt      out  CNT_W     executed JALRs, saturating
//   ras_miss_cnt  out  CNT_W     pops with ras_pred_ok=0 (incl. empty), saturating
// BEHAVIOUR
//   - Reset: pc=PC_RESET, ras_count=0, pointers=0, ras_ovf=ras_unf=0, counters=0.
//   - next_pc: JAL pc+imm; JALR (rs1_data+imm)&~1; branch&taken pc+imm; else pc+4.
//     All adds modulo 2^XLEN. !instr_valid -> next_pc=pc.
//   - pc<=next_pc on clk when instr_valid & !stall & !misalign_exc (1-cycle latency).
//   - link_we=instr_valid&(is_jal|is_jalr)&(rd!=0), comb; independent of stall.
//   - link(r)= r==1|r==5. Push on JAL/JALR with link(rd); pop on JALR with link(rs1):
//     rd!link,rs1 link -> pop; both link, rd!=rs1 -> pop then push (top replaced);
//     both link, rd==rs1 -> push only. Push value = pc+4.
//   - Full push: circular overwrite of oldest, count stays RAS_DEPTH, ras_ovf<=1.
//   - Empty pop: pointer/count unchanged, ras_pred_vld=0, ras_unf<=1, miss counted.
//   - Pop+push same cycle: count unchanged, top entry overwritten.
//   - stall=1: no state changes; outputs still combinational on inputs.
//   - Counters saturate at all-ones; sticky flags clear only on rst.
//   - rst mid-operation wins over all events in that cycle.
// STRUCTURE
//   - pkg rv_ctrl_pkg: opcode class constants, LINK_X1=5'd1, LINK_X5=5'd5, XLEN default.
//   - Sub-module ras_stack (push, pop, push_data, top, count, ovf, unf; circular buffer).
//   - Top: PC reg, target adders, RAS hint decode, statistics counters.
// TESTING
//   - rst 3 cycles -> pc=0, ras_count=0, all counters/flags 0.
//   - pc=0x4, JALR rd=3 rs1=2 rs1_data=0xa imm=0x4 -> link_we=1, link_rd=3,
//     link_data=0x8 same cycle; next cycle pc=0xe (ALIGN_CHECK=0), jalr_cnt=1.
//   - JAL rd=1 at pc=0x10 imm=0x20 -> pc=0x30, ras_count=1; JALR rd=0 rs1=1
//     rs1_data=0x14 imm=0 -> ras_pred_vld=1, ras_pred_ok=1, pc=0x14, ras_count=0.
//   - 9 JAL rd=1 pushes (DEPTH=8) -> ras_count=8, ras_ovf=1; 8 pops return newest 8
//     addresses in LIFO order; 9th pop -> ras_unf=1, ras_miss_cnt+=1.
//   - stall=1 with JAL rd=1 -> pc, ras_count unchanged; link_we still 1.
//   - ALIGN_CHECK=1, JALR target 0x6 -> misalign_exc=1, pc held; assert rst while
//     ras_count=3 -> next cycle all state at reset values.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants and helpers for the control-transfer path: opcode classes,
// link-register identities and the RAS operation encoding.
package rv_ctrl_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [4:0] LINK_X1 = 5'd1;
   localparam logic [4:0] LINK_X5 = 5'd5;

   typedef enum logic [1:0] {
      RAS_NONE    = 2'b00,
      RAS_PUSH    = 2'b01,
      RAS_POP     = 2'b10,
      RAS_POPPUSH = 2'b11
   } ras_op_e;

   function automatic logic is_link(input logic [4:0] r);
      return (r == LINK_X1) || (r == LINK_X5);
   endfunction

endpackage

// File: rtl/ctrl_xfer_unit_if.sv
// Decode-side request and PC/RAS result bundle of the control-transfer unit.
// slave is the unit itself, master is the decode/fetch side driving it.
interface ctrl_xfer_unit_if
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int RAS_DEPTH = 8,
   parameter int CNT_W     = 16
);
   logic                         stall;
   logic                         instr_valid;
   logic                         is_jal;
   logic                         is_jalr;
   logic                         is_branch;
   logic                         branch_taken;
   logic [4:0]                   rd;
   logic [4:0]                   rs1;
   logic [XLEN-1:0]              rs1_data;
   logic [XLEN-1:0]              imm;
   logic [XLEN-1:0]              pc;
   logic [XLEN-1:0]              next_pc;
   logic                         link_we;
   logic [4:0]                   link_rd;
   logic [XLEN-1:0]              link_data;
   logic                         ras_pred_vld;
   logic                         ras_pred_ok;
   logic [$clog2(RAS_DEPTH):0]   ras_count;
   logic                         ras_ovf;
   logic                         ras_unf;
   logic                         misalign_exc;
   logic [CNT_W-1:0]             jalr_cnt;
   logic [CNT_W-1:0]             ras_miss_cnt;

   modport slave (
      input  stall, instr_valid, is_jal, is_jalr, is_branch, branch_taken,
             rd, rs1, rs1_data, imm,
      output pc, next_pc, link_we, link_rd, link_data, ras_pred_vld,
             ras_pred_ok, ras_count, ras_ovf, ras_unf, misalign_exc,
             jalr_cnt, ras_miss_cnt
   );

   modport master (
      output stall, instr_valid, is_jal, is_jalr, is_branch, branch_taken,
             rd, rs1, rs1_data, imm,
      input  pc, next_pc, link_we, link_rd, link_data, ras_pred_vld,
             ras_pred_ok, ras_count, ras_ovf, ras_unf, misalign_exc,
             jalr_cnt, ras_miss_cnt
   );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a push at full silently replaces the oldest
// entry, a pop at empty leaves the stack untouched; both raise sticky flags.
module ras_stack
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [XLEN-1:0]          push_data,
   output logic [XLEN-1:0]          top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     unf
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [XLEN-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] sp;
   logic [PTR_W-1:0] sp_top;
   logic             empty;
   logic             full;
   ras_op_e          op;

   // sp is the next free slot; wrapping makes it also the oldest slot when full
   assign sp_top = sp - 1'b1;
   assign top    = mem[sp_top];
   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);

   always_comb begin
      op = RAS_NONE;
      case ({pop, push})
         2'b01:   op = RAS_PUSH;
         2'b10:   op = RAS_POP;
         2'b11:   op = RAS_POPPUSH;
         default: op = RAS_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         case (op)
            RAS_PUSH: begin
               sp <= sp + 1'b1;
               if (full) ovf   <= 1'b1;
               else      count <= count + 1'b1;
            end
            RAS_POP: begin
               if (empty) begin
                  unf <= 1'b1;
               end else begin
                  sp    <= sp_top;
                  count <= count - 1'b1;
               end
            end
            RAS_POPPUSH: begin
               // an empty pop is a no-op, so the push then lands as a plain push
               if (empty) begin
                  unf   <= 1'b1;
                  sp    <= sp + 1'b1;
                  count <= count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      case (op)
         RAS_PUSH:    mem[sp] <= push_data;
         RAS_POPPUSH: begin
            if (empty) mem[sp]     <= push_data;
            else       mem[sp_top] <= push_data;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_xfer_unit.sv
// PC owner: resolves JAL/JALR/branch targets, drives the rd link write and
// predicts JALR returns with a return-address stack plus miss statistics.
module ctrl_xfer_unit
   import rv_ctrl_pkg::*;
#(
   parameter int              XLEN        = XLEN_DEF,
   parameter int              RAS_DEPTH   = 8,
   parameter logic [XLEN-1:0] PC_RESET    = '0,
   parameter int              ALIGN_CHECK = 0,
   parameter int              CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   ctrl_xfer_unit_if.slave    bus
);
   logic [XLEN-1:0]  pc_p0;
   logic [XLEN-1:0]  pc_plus4;
   logic [XLEN-1:0]  rel_tgt;
   logic [XLEN-1:0]  jalr_sum;
   logic [XLEN-1:0]  jalr_tgt;
   logic [XLEN-1:0]  nxt_pc;
   logic             xfer;
   logic             misalign;
   logic             advance;
   logic             rd_link;
   logic             rs1_link;
   logic             push_req;
   logic             pop_req;
   logic             pred_vld;
   logic             pred_ok;
   logic [XLEN-1:0]  ras_top;
   logic [$clog2(RAS_DEPTH):0] ras_cnt;
   logic [CNT_W-1:0] jalr_cnt_p0;
   logic [CNT_W-1:0] miss_cnt_p0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign pc_plus4 = pc_p0 + XLEN'(4);
   assign rel_tgt  = pc_p0 + bus.imm;
   assign jalr_sum = bus.rs1_data + bus.imm;
   assign jalr_tgt = jalr_sum & ~XLEN'(1);

   always_comb begin
      nxt_pc = pc_p0;
      if (bus.instr_valid) begin
         if (bus.is_jal)                           nxt_pc = rel_tgt;
         else if (bus.is_jalr)                     nxt_pc = jalr_tgt;
         else if (bus.is_branch && bus.branch_taken) nxt_pc = rel_tgt;
         else                                      nxt_pc = pc_plus4;
      end
   end

   // only redirected targets can be misaligned; pc+4 keeps an aligned pc aligned
   assign xfer     = bus.instr_valid &
                     (bus.is_jal | bus.is_jalr | (bus.is_branch & bus.branch_taken));
   assign misalign = (ALIGN_CHECK != 0) && xfer && nxt_pc[1];
   assign advance  = bus.instr_valid & ~bus.stall & ~misalign;

   assign rd_link  = is_link(bus.rd);
   assign rs1_link = is_link(bus.rs1);
   assign push_req = bus.instr_valid & (bus.is_jal | bus.is_jalr) & rd_link;
   assign pop_req  = bus.instr_valid & bus.is_jalr & rs1_link &
                     ~(rd_link && (bus.rd == bus.rs1));
   assign pred_vld = pop_req & (ras_cnt != '0);
   assign pred_ok  = pred_vld & (ras_top == jalr_tgt);

   ras_stack #(
      .XLEN      (XLEN),
      .DEPTH     (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req & advance),
      .pop       (pop_req & advance),
      .push_data (pc_plus4),
      .top       (ras_top),
      .count     (ras_cnt),
      .ovf       (bus.ras_ovf),
      .unf       (bus.ras_unf)
   );

   // ---- p0: architectural PC and statistics ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p0       <= PC_RESET;
         jalr_cnt_p0 <= '0;
         miss_cnt_p0 <= '0;
      end else if (advance) begin
         pc_p0 <= nxt_pc;
         if (bus.is_jalr)          jalr_cnt_p0 <= sat_inc(jalr_cnt_p0);
         if (pop_req && !pred_ok)  miss_cnt_p0 <= sat_inc(miss_cnt_p0);
      end
   end

   assign bus.pc           = pc_p0;
   assign bus.next_pc      = nxt_pc;
   assign bus.link_we      = bus.instr_valid & (bus.is_jal | bus.is_jalr) & (bus.rd != 5'd0);
   assign bus.link_rd      = bus.rd;
   assign bus.link_data    = pc_plus4;
   assign bus.ras_pred_vld = pred_vld;
   assign bus.ras_pred_ok  = pred_ok;
   assign bus.ras_count    = ras_cnt;
   assign bus.misalign_exc = misalign;
   assign bus.jalr_cnt     = jalr_cnt_p0;
   assign bus.ras_miss_cnt = miss_cnt_p0;

endmodule

// File: tb/tb_ctrl_xfer_unit.sv
// Directed bench for ctrl_xfer_unit: one instance without and one with
// alignment checking, both fed the same decode stream, checked via a scoreboard.
module tb_ctrl_xfer_unit;

   localparam int ID_PC0 = 0,  ID_NPC0 = 1,  ID_LWE0 = 2,  ID_LRD0 = 3;
   localparam int ID_LDATA0 = 4, ID_PVLD0 = 5, ID_POK0 = 6, ID_CNT0 = 7;
   localparam int ID_OVF0 = 8, ID_UNF0 = 9,  ID_JC0 = 10,  ID_MC0 = 11;
   localparam int ID_EXC0 = 12, ID_PC1 = 13, ID_CNT1 = 14, ID_OVF1 = 15;
   localparam int ID_UNF1 = 16, ID_JC1 = 17, ID_MC1 = 18,  ID_EXC1 = 19;

   typedef struct {
      int          id;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        instr_valid, is_jal, is_jalr, is_branch, branch_taken;
   logic [4:0]  rd, rs1;
   logic [31:0] rs1_data, imm;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ctrl_xfer_unit_if #(.XLEN(32), .RAS_DEPTH(8), .CNT_W(16)) bus0 ();
   ctrl_xfer_unit_if #(.XLEN(32), .RAS_DEPTH(8), .CNT_W(16)) bus1 ();

   assign bus0.stall = stall;        assign bus1.stall = stall;
   assign bus0.instr_valid = instr_valid;  assign bus1.instr_valid = instr_valid;
   assign bus0.is_jal = is_jal;      assign bus1.is_jal = is_jal;
   assign bus0.is_jalr = is_jalr;    assign bus1.is_jalr = is_jalr;
   assign bus0.is_branch = is_branch;      assign bus1.is_branch = is_branch;
   assign bus0.branch_taken = branch_taken; assign bus1.branch_taken = branch_taken;
   assign bus0.rd = rd;              assign bus1.rd = rd;
   assign bus0.rs1 = rs1;            assign bus1.rs1 = rs1;
   assign bus0.rs1_data = rs1_data;  assign bus1.rs1_data = rs1_data;
   assign bus0.imm = imm;            assign bus1.imm = imm;

   ctrl_xfer_unit #(
      .XLEN(32), .RAS_DEPTH(8), .PC_RESET(32'h0), .ALIGN_CHECK(0), .CNT_W(16)
   ) u0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   ctrl_xfer_unit #(
      .XLEN(32), .RAS_DEPTH(8), .PC_RESET(32'h0), .ALIGN_CHECK(1), .CNT_W(16)
   ) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   function automatic string tag(input int id);
      case (id)
         ID_PC0:    return "pc0";
         ID_NPC0:   return "next_pc0";
         ID_LWE0:   return "link_we0";
         ID_LRD0:   return "link_rd0";
         ID_LDATA0: return "link_data0";
         ID_PVLD0:  return "ras_pred_vld0";
         ID_POK0:   return "ras_pred_ok0";
         ID_CNT0:   return "ras_count0";
         ID_OVF0:   return "ras_ovf0";
         ID_UNF0:   return "ras_unf0";
         ID_JC0:    return "jalr_cnt0";
         ID_MC0:    return "ras_miss_cnt0";
         ID_EXC0:   return "misalign_exc0";
         ID_PC1:    return "pc1";
         ID_CNT1:   return "ras_count1";
         ID_OVF1:   return "ras_ovf1";
         ID_UNF1:   return "ras_unf1";
         ID_JC1:    return "jalr_cnt1";
         ID_MC1:    return "ras_miss_cnt1";
         default:   return "misalign_exc1";
      endcase
   endfunction

   function automatic logic [31:0] observe(input int id);
      case (id)
         ID_PC0:    return bus0.pc;
         ID_NPC0:   return bus0.next_pc;
         ID_LWE0:   return 32'(bus0.link_we);
         ID_LRD0:   return 32'(bus0.link_rd);
         ID_LDATA0: return bus0.link_data;
         ID_PVLD0:  return 32'(bus0.ras_pred_vld);
         ID_POK0:   return 32'(bus0.ras_pred_ok);
         ID_CNT0:   return 32'(bus0.ras_count);
         ID_OVF0:   return 32'(bus0.ras_ovf);
         ID_UNF0:   return 32'(bus0.ras_unf);
         ID_JC0:    return 32'(bus0.jalr_cnt);
         ID_MC0:    return 32'(bus0.ras_miss_cnt);
         ID_EXC0:   return 32'(bus0.misalign_exc);
         ID_PC1:    return bus1.pc;
         ID_CNT1:   return 32'(bus1.ras_count);
         ID_OVF1:   return 32'(bus1.ras_ovf);
         ID_UNF1:   return 32'(bus1.ras_unf);
         ID_JC1:    return 32'(bus1.jalr_cnt);
         ID_MC1:    return 32'(bus1.ras_miss_cnt);
         default:   return 32'(bus1.misalign_exc);
      endcase
   endfunction

   task automatic expect_val(input int id, input logic [31:0] v);
      exp_t e;
      e.id  = id;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.id);
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag(e.id), obs, e.val);
         end
      end
   endtask

   task automatic drv(input logic v, input logic j, input logic jr, input logic b,
                      input logic t, input logic [4:0] d, input logic [4:0] s,
                      input logic [31:0] sd, input logic [31:0] im);
      instr_valid  = v;
      is_jal       = j;
      is_jalr      = jr;
      is_branch    = b;
      branch_taken = t;
      rd           = d;
      rs1          = s;
      rs1_data     = sd;
      imm          = im;
   endtask

   task automatic settle_check();
      #1;
      check_all();
   endtask

   task automatic clk_check();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst   = 1'b1;
      stall = 1'b0;
      drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      expect_val(ID_PC0, 32'h0);  expect_val(ID_CNT0, 0); expect_val(ID_OVF0, 0);
      expect_val(ID_UNF0, 0);     expect_val(ID_JC0, 0);  expect_val(ID_MC0, 0);
      expect_val(ID_PC1, 32'h0);  expect_val(ID_CNT1, 0);
      check_all();
      rst = 1'b0;

      // sequential step to pc=0x4
      drv(1, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      expect_val(ID_NPC0, 32'h4); settle_check();
      expect_val(ID_PC0, 32'h4);  clk_check();

      // JALR rd=3 rs1=2: non-link, target 0xe
      drv(1, 0, 1, 0, 0, 5'd3, 5'd2, 32'ha, 32'h4);
      expect_val(ID_LWE0, 1); expect_val(ID_LRD0, 3); expect_val(ID_LDATA0, 32'h8);
      expect_val(ID_NPC0, 32'he); expect_val(ID_PVLD0, 0); expect_val(ID_EXC0, 0);
      settle_check();
      expect_val(ID_PC0, 32'he); expect_val(ID_JC0, 1); expect_val(ID_MC0, 0);
      clk_check();

      // JAL rd=0 to 0x10: no link write
      drv(1, 1, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h2);
      expect_val(ID_LWE0, 0); settle_check();
      expect_val(ID_PC0, 32'h10); clk_check();

      // call: JAL rd=1 imm=0x20
      drv(1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h0, 32'h20);
      expect_val(ID_LWE0, 1); expect_val(ID_LDATA0, 32'h14); expect_val(ID_NPC0, 32'h30);
      settle_check();
      expect_val(ID_PC0, 32'h30); expect_val(ID_CNT0, 1); clk_check();

      // return: JALR rd=0 rs1=1 to 0x14
      drv(1, 0, 1, 0, 0, 5'd0, 5'd1, 32'h14, 32'h0);
      expect_val(ID_PVLD0, 1); expect_val(ID_POK0, 1); expect_val(ID_NPC0, 32'h14);
      expect_val(ID_LWE0, 0);
      settle_check();
      expect_val(ID_PC0, 32'h14); expect_val(ID_CNT0, 0); expect_val(ID_JC0, 2);
      expect_val(ID_MC0, 0);
      clk_check();

      // branch taken backwards, then not taken, then no instruction
      drv(1, 0, 0, 1, 1, 5'd0, 5'd0, 32'h0, 32'hffff_fff8);
      expect_val(ID_NPC0, 32'hc); settle_check();
      expect_val(ID_PC0, 32'hc); clk_check();
      drv(1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h0, 32'hffff_fff8);
      expect_val(ID_NPC0, 32'h10); settle_check();
      expect_val(ID_PC0, 32'h10); clk_check();
      drv(0, 1, 0, 0, 0, 5'd1, 5'd0, 32'h0, 32'h40);
      expect_val(ID_NPC0, 32'h10); expect_val(ID_LWE0, 0); settle_check();
      expect_val(ID_PC0, 32'h10); expect_val(ID_CNT0, 0); clk_check();

      // nine calls into a depth-8 stack: last one overwrites the oldest
      for (int k = 0; k < 9; k++) begin
         drv(1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h0, 32'h4);
         expect_val(ID_LDATA0, 32'h14 + 32'(4 * k)); settle_check();
         expect_val(ID_CNT0, (k < 8) ? 32'(k + 1) : 32'd8);
         expect_val(ID_OVF0, (k == 8) ? 32'd1 : 32'd0);
         clk_check();
      end
      expect_val(ID_PC0, 32'h34); check_all();

      // eight returns come back newest-first
      for (int k = 0; k < 8; k++) begin
         drv(1, 0, 1, 0, 0, 5'd0, 5'd1, 32'h34 - 32'(4 * k), 32'h0);
         expect_val(ID_PVLD0, 1); expect_val(ID_POK0, 1); settle_check();
         expect_val(ID_PC0, 32'h34 - 32'(4 * k)); expect_val(ID_CNT0, 32'(7 - k));
         clk_check();
      end
      expect_val(ID_JC0, 10); expect_val(ID_MC0, 0); expect_val(ID_OVF0, 1);
      expect_val(ID_UNF0, 0);
      check_all();

      // pop at empty
      drv(1, 0, 1, 0, 0, 5'd0, 5'd1, 32'h100, 32'h0);
      expect_val(ID_PVLD0, 0); expect_val(ID_POK0, 0); settle_check();
      expect_val(ID_PC0, 32'h100); expect_val(ID_CNT0, 0); expect_val(ID_UNF0, 1);
      expect_val(ID_MC0, 1); expect_val(ID_JC0, 11);
      clk_check();

      // stalled call: nothing moves but the link write is still requested
      stall = 1'b1;
      drv(1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h0, 32'h40);
      expect_val(ID_LWE0, 1); expect_val(ID_NPC0, 32'h140); settle_check();
      expect_val(ID_PC0, 32'h100); expect_val(ID_CNT0, 0); expect_val(ID_JC0, 11);
      clk_check();
      stall = 1'b0;

      // push, then a pop+push (rd=5, rs1=1) replacing the top
      drv(1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h0, 32'h4);
      expect_val(ID_LDATA0, 32'h104); settle_check();
      expect_val(ID_PC0, 32'h104); expect_val(ID_CNT0, 1); clk_check();
      drv(1, 0, 1, 0, 0, 5'd5, 5'd1, 32'h104, 32'h10);
      expect_val(ID_PVLD0, 1); expect_val(ID_POK0, 0); expect_val(ID_NPC0, 32'h114);
      expect_val(ID_LDATA0, 32'h108);
      settle_check();
      expect_val(ID_PC0, 32'h114); expect_val(ID_CNT0, 1); expect_val(ID_MC0, 2);
      expect_val(ID_JC0, 12);
      clk_check();
      drv(1, 0, 1, 0, 0, 5'd0, 5'd5, 32'h108, 32'h0);
      expect_val(ID_PVLD0, 1); expect_val(ID_POK0, 1); settle_check();
      expect_val(ID_PC0, 32'h108); expect_val(ID_CNT0, 0); expect_val(ID_MC0, 2);
      clk_check();

      // rd == rs1 == x1: push only
      drv(1, 0, 1, 0, 0, 5'd1, 5'd1, 32'h200, 32'h0);
      expect_val(ID_PVLD0, 0); settle_check();
      expect_val(ID_PC0, 32'h200); expect_val(ID_CNT0, 1); expect_val(ID_MC0, 2);
      expect_val(ID_JC0, 14);
      clk_check();

      // reset both instances before the alignment-checked sequence
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      expect_val(ID_PC0, 32'h0); expect_val(ID_CNT0, 0); expect_val(ID_OVF0, 0);
      expect_val(ID_UNF0, 0);    expect_val(ID_JC0, 0);  expect_val(ID_MC0, 0);
      expect_val(ID_PC1, 32'h0);
      check_all();
      rst = 1'b0;

      // JALR to 0x6: only the checked instance raises and holds
      drv(1, 0, 1, 0, 0, 5'd0, 5'd2, 32'h2, 32'h4);
      expect_val(ID_EXC1, 1); expect_val(ID_EXC0, 0); expect_val(ID_NPC0, 32'h6);
      settle_check();
      expect_val(ID_PC1, 32'h0); expect_val(ID_PC0, 32'h6); clk_check();

      // empty-stack return on the checked instance, then three calls
      drv(1, 0, 1, 0, 0, 5'd0, 5'd1, 32'h8, 32'h0);
      expect_val(ID_EXC1, 0); settle_check();
      expect_val(ID_PC1, 32'h8); expect_val(ID_UNF1, 1); expect_val(ID_MC1, 1);
      expect_val(ID_JC1, 1);
      clk_check();
      for (int k = 0; k < 3; k++) begin
         drv(1, 1, 0, 0, 0, 5'd1, 5'd0, 32'h0, 32'h8);
         expect_val(ID_CNT1, 32'(k + 1));
         clk_check();
      end
      expect_val(ID_PC1, 32'h20); check_all();

      // reset lands while a call is still being presented
      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_val(ID_PC1, 32'h0); expect_val(ID_CNT1, 0); expect_val(ID_UNF1, 0);
      expect_val(ID_OVF1, 0);    expect_val(ID_JC1, 0);  expect_val(ID_MC1, 0);
      check_all();
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
